mfcc_context_stacker: RTL



---
 rtl/mfcc_pkg.sv | 19 +
 rtl/mfcc_frame_assembler.sv | 88 ++++++++
 rtl/mfcc_context_stacker.sv | 112 +++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// mfcc_pkg
// Shared constants and helpers for the MFCC front end and the DNN input
// stage that consumes its context vectors.
//   NCOEF_DEF / CBIT_DEF / IDXW_DEF : default frame geometry
//   slice_offset()                  : bit offset of coefficient c of frame k
//                                     inside a packed context vector
package mfcc_pkg;

  localparam int NCOEF_DEF = 12;
  localparam int CBIT_DEF  = 32;
  localparam int IDXW_DEF  = 5;

  // Frame k (0 = oldest) coefficient c lives at [offset +: cbit].
  function automatic int slice_offset(input int k, input int c,
                                      input int ncoef, input int cbit);
    return (k * ncoef + c) * cbit;
  endfunction

endpackage

// File: rtl/mfcc_frame_assembler.sv
// mfcc_frame_assembler
// Turns the level-signalled MFCC coefficient stream into complete frames.
// A rising edge on dv_in captures one coefficient into the slot named by
// idx_in. Indices must arrive 0..NCOEF-1 in order; anything else raises
// sync_err and restarts assembly (an out-of-order index 0 starts a new frame).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   dv_in             : data-valid level, rising edge = new coefficient
//   idx_in, x_in      : coefficient index and value
//   vad_in            : voice-activity flag, sampled with the final coefficient
//   frame             : assembled frame, valid while done is high
//   vad               : VAD flag belonging to frame
//   done              : combinational strobe, high in the cycle whose edge
//                       captures the final in-sequence coefficient
//   sync_err          : registered one-cycle pulse after a bad index capture
module mfcc_frame_assembler
  import mfcc_pkg::*;
#(
  parameter int NCOEF = NCOEF_DEF,
  parameter int CBIT  = CBIT_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dv_in,
  input  logic [IDXW-1:0]       idx_in,
  input  logic [CBIT-1:0]       x_in,
  input  logic                  vad_in,
  output logic [NCOEF*CBIT-1:0] frame,
  output logic                  vad,
  output logic                  done,
  output logic                  sync_err
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NCOEF - 1);

  logic            dv_d;
  logic [IDXW-1:0] exp_idx;
  logic [CBIT-1:0] slot [NCOEF];
  logic            capture;
  logic            in_seq;

  assign capture = dv_in & ~dv_d;
  assign in_seq  = (idx_in == exp_idx);
  assign done    = capture & in_seq & (exp_idx == LAST);
  assign vad     = vad_in;

  // The final coefficient is forwarded straight from x_in so the window can
  // take the frame on the same edge that captures it.
  always_comb begin
    frame = '0;
    for (int c = 0; c < NCOEF - 1; c++) begin
      frame[slice_offset(0, c, NCOEF, CBIT) +: CBIT] = slot[c];
    end
    frame[slice_offset(0, NCOEF - 1, NCOEF, CBIT) +: CBIT] =
      done ? x_in : slot[NCOEF-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // dv_d starts high so a level already present at release is ignored.
      dv_d     <= 1'b1;
      exp_idx  <= '0;
      sync_err <= 1'b0;
      for (int c = 0; c < NCOEF; c++) slot[c] <= '0;
    end else begin
      dv_d     <= dv_in;
      sync_err <= 1'b0;
      if (capture) begin
        if (in_seq) begin
          for (int c = 0; c < NCOEF; c++) begin
            if (IDXW'(c) == exp_idx) slot[c] <= x_in;
          end
          exp_idx <= (exp_idx == LAST) ? '0 : exp_idx + IDXW'(1);
        end else begin
          sync_err <= 1'b1;
          if (idx_in == '0) begin
            slot[0] <= x_in;
            exp_idx <= IDXW'(1);
          end else begin
            exp_idx <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mfcc_context_stacker.sv
// mfcc_context_stacker
// Keeps a sliding window of the last NCTX completed MFCC frames and offers
// each full window to the DNN input stage over a valid/ready handshake.
// With GATE_VAD=1 a non-speech frame is dropped and restarts the window.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   dv_in, idx_in,
//   x_in, vad_in      : MFCC coefficient stream (see mfcc_frame_assembler)
//   frame_o           : context vector, frame 0 (oldest) in the low bits
//   frame_valid       : frame_o holds a window not yet taken
//   frame_ready       : consumer takes frame_o when frame_valid is high
//   sync_err          : one-cycle pulse, coefficient index out of sequence
//   overrun           : one-cycle pulse, new window could not be loaded
module mfcc_context_stacker
  import mfcc_pkg::*;
#(
  parameter int NCOEF    = NCOEF_DEF,
  parameter int CBIT     = CBIT_DEF,
  parameter int NCTX     = 5,
  parameter int IDXW     = IDXW_DEF,
  parameter int GATE_VAD = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dv_in,
  input  logic [IDXW-1:0]            idx_in,
  input  logic [CBIT-1:0]            x_in,
  input  logic                       vad_in,
  output logic [NCTX*NCOEF*CBIT-1:0] frame_o,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       sync_err,
  output logic                       overrun
);

  localparam int FW   = NCOEF * CBIT;
  localparam int WW   = NCTX * FW;
  localparam int CNTW = $clog2(NCTX + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(NCTX);

  logic [FW-1:0]   asm_frame;
  logic            asm_vad;
  logic            asm_done;
  logic [WW-1:0]   win;
  logic [WW-1:0]   win_shifted;
  logic [CNTW-1:0] count;
  logic            shifted;
  logic            load_req;

  mfcc_frame_assembler #(
    .NCOEF (NCOEF),
    .CBIT  (CBIT),
    .IDXW  (IDXW)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .dv_in    (dv_in),
    .idx_in   (idx_in),
    .x_in     (x_in),
    .vad_in   (vad_in),
    .frame    (asm_frame),
    .vad      (asm_vad),
    .done     (asm_done),
    .sync_err (sync_err)
  );

  // Oldest frame falls off the bottom, newest enters at the top slice.
  always_comb begin
    win_shifted = win >> FW;
    win_shifted[slice_offset(NCTX - 1, 0, NCOEF, CBIT) +: FW] = asm_frame;
  end

  // A load is only requested the cycle after a shift, so an overrun window
  // is not retried until the next completed frame arrives.
  assign load_req = shifted & (count == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      win         <= '0;
      count       <= '0;
      shifted     <= 1'b0;
      frame_o     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      shifted <= 1'b0;
      overrun <= 1'b0;

      if (asm_done) begin
        if ((GATE_VAD != 0) && !asm_vad) begin
          count <= '0;
        end else begin
          win     <= win_shifted;
          shifted <= 1'b1;
          if (count != FULL) count <= count + CNTW'(1);
        end
      end

      if (load_req) begin
        if (!frame_valid || frame_ready) begin
          frame_o     <= win;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
